// File: rtl/spi_master_slave.sv
// Byte-wide SPI master and SPI slave sharing one clock, for full-duplex loopback use.
// Master drives sclk/mosi from a start handshake; slave is selected by an external active-low cs.
module spi_master_slave #(
  parameter int unsigned SCLK_HALF = 50
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cpol_i,
  input  logic       cpha_i,
  input  logic       start_i,
  input  logic [7:0] tx_data_i,
  output logic [7:0] rx_data_o,
  output logic       tx_ready_o,
  output logic       done_o,
  output logic       sclk_o,
  output logic       mosi_o,
  output logic       miso_o,
  input  logic       cs_i,
  output logic [7:0] si_data_o,
  output logic       si_done_o,
  input  logic [7:0] so_data_i,
  input  logic       so_start_i,
  output logic       so_ready_o
);

  localparam int unsigned CntW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(SCLK_HALF - 1);

  typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            half_q;
  logic [2:0]      bit_q;
  logic [7:0]      tx_sh_q, rx_sh_q, rx_data_q;
  logic            cpol_q, cpha_q, sclk_q, mosi_q, done_q, tx_ready_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      half_q     <= 1'b0;
      bit_q      <= 3'd0;
      tx_sh_q    <= 8'h00;
      rx_sh_q    <= 8'h00;
      rx_data_q  <= 8'h00;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      done_q     <= 1'b0;
      tx_ready_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          sclk_q <= cpol_i;
          if (start_i) begin
            state_q    <= StXfer;
            tx_ready_q <= 1'b0;
            cpol_q     <= cpol_i;
            cpha_q     <= cpha_i;
            tx_sh_q    <= tx_data_i;
            mosi_q     <= tx_data_i[7];
            sclk_q     <= cpol_i ^ cpha_i;
            cnt_q      <= '0;
            half_q     <= 1'b0;
            bit_q      <= 3'd7;
          end
        end
        StXfer: begin
          if (cnt_q == CntMax) begin
            cnt_q <= '0;
            if (!half_q) begin
              // Entering the second half: sample MISO here for both cpha settings.
              half_q  <= 1'b1;
              sclk_q  <= ~(cpol_q ^ cpha_q);
              rx_sh_q <= {rx_sh_q[6:0], miso_o};
            end else begin
              half_q <= 1'b0;
              if (bit_q == 3'd0) begin
                state_q   <= StDone;
                sclk_q    <= cpol_q;
                done_q    <= 1'b1;
                rx_data_q <= rx_sh_q;
              end else begin
                bit_q   <= bit_q - 3'd1;
                tx_sh_q <= {tx_sh_q[6:0], 1'b0};
                mosi_q  <= tx_sh_q[6];
                sclk_q  <= cpol_q ^ cpha_q;
              end
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDone: begin
          tx_ready_q <= 1'b1;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  logic [2:0] sclk_sync_q, cs_sync_q;
  logic [1:0] mosi_sync_q;
  logic [2:0] bcnt_q;
  logic [7:0] srx_q, stx_q, si_data_q;
  logic       miso_q, si_done_q, so_ready_q;

  logic sclk_s, sclk_edge, lead_e, trail_e, sample_e, shift_e, cs_s, cs_rise;

  always_comb begin
    sclk_s    = sclk_sync_q[1];
    sclk_edge = sclk_sync_q[1] ^ sclk_sync_q[2];
    lead_e    = sclk_edge & (sclk_s != cpol_i);
    trail_e   = sclk_edge & (sclk_s == cpol_i);
    sample_e  = cpha_i ? trail_e : lead_e;
    shift_e   = cpha_i ? lead_e : trail_e;
    cs_s      = cs_sync_q[1];
    cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_sync_q <= 3'b000;
      cs_sync_q   <= 3'b111;
      mosi_sync_q <= 2'b00;
      bcnt_q      <= 3'd0;
      srx_q       <= 8'h00;
      stx_q       <= 8'h00;
      si_data_q   <= 8'h00;
      miso_q      <= 1'b0;
      si_done_q   <= 1'b0;
      so_ready_q  <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], sclk_q};
      cs_sync_q   <= {cs_sync_q[1:0], cs_i};
      mosi_sync_q <= {mosi_sync_q[0], mosi_q};
      si_done_q   <= 1'b0;
      if (cs_s) begin
        bcnt_q <= 3'd0;
        if (cs_rise && (bcnt_q != 3'd0)) begin
          so_ready_q <= 1'b1;
          stx_q      <= 8'h00;
          miso_q     <= 1'b0;
        end
      end else begin
        if (sample_e) begin
          srx_q <= {srx_q[6:0], mosi_sync_q[1]};
          if (bcnt_q == 3'd7) begin
            bcnt_q     <= 3'd0;
            si_data_q  <= {srx_q[6:0], mosi_sync_q[1]};
            si_done_q  <= 1'b1;
            so_ready_q <= 1'b1;
            stx_q      <= 8'h00;
            miso_q     <= 1'b0;
          end else begin
            bcnt_q <= bcnt_q + 3'd1;
          end
        end
        // A shift edge with no bit sampled yet (or just after bit 0) carries no new bit.
        if (shift_e && (bcnt_q != 3'd0)) begin
          stx_q  <= {stx_q[6:0], 1'b0};
          miso_q <= stx_q[6];
        end
      end
      if (so_start_i && so_ready_q) begin
        stx_q      <= so_data_i;
        miso_q     <= so_data_i[7];
        so_ready_q <= 1'b0;
      end
    end
  end

  assign rx_data_o  = rx_data_q;
  assign tx_ready_o = tx_ready_q;
  assign done_o     = done_q;
  assign sclk_o     = sclk_q;
  assign mosi_o     = mosi_q;
  assign miso_o     = miso_q & ~cs_i;
  assign si_data_o  = si_data_q;
  assign si_done_o  = si_done_q;
  assign so_ready_o = so_ready_q;

endmodule

// File: tb/tb_spi_master_slave.sv
// Directed bench for spi_master_slave: master/slave loopback with a queue scoreboard per direction.
module tb_spi_master_slave;
  localparam int unsigned H = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cpol = 1'b0, cpha = 1'b0, start = 1'b0, cs = 1'b1, so_start = 1'b0;
  logic [7:0] tx_data = 8'h00, so_data = 8'h00;
  logic [7:0] rx_data, si_data;
  logic       tx_ready, done, sclk, mosi, miso, si_done, so_ready;

  always #5 clk = ~clk;

  spi_master_slave #(.SCLK_HALF(H)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .cpol_i     (cpol),
    .cpha_i     (cpha),
    .start_i    (start),
    .tx_data_i  (tx_data),
    .rx_data_o  (rx_data),
    .tx_ready_o (tx_ready),
    .done_o     (done),
    .sclk_o     (sclk),
    .mosi_o     (mosi),
    .miso_o     (miso),
    .cs_i       (cs),
    .si_data_o  (si_data),
    .si_done_o  (si_done),
    .so_data_i  (so_data),
    .so_start_i (so_start),
    .so_ready_o (so_ready)
  );

  int checks = 0, failures = 0;
  int exp_rx[$], exp_si[$];
  int n_done = 0, n_si = 0;
  int e_rx, e_si;
  logic [7:0] mosi_cap = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // -1 in a queue entry means the byte is expected but its value is not checked.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        n_done++;
        chk("done_expected", exp_rx.size() > 0, 1);
        if (exp_rx.size() > 0) begin
          e_rx = exp_rx.pop_front();
          if (e_rx >= 0) chk("rx_data", rx_data, e_rx);
        end
      end
      if (si_done) begin
        n_si++;
        chk("si_done_expected", exp_si.size() > 0, 1);
        if (exp_si.size() > 0) begin
          e_si = exp_si.pop_front();
          if (e_si >= 0) chk("si_data", si_data, e_si);
        end
      end
    end
  end

  always @(posedge sclk) mosi_cap <= {mosi_cap[6:0], mosi};

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge where done is seen (or the bound expires).
  task automatic xfer(input logic [7:0] m, input int exp_m, input int exp_s, input int sload,
                      input bit timed, input bit poke, input int cs_at);
    int n;
    chk("tx_ready_idle", tx_ready, 1);
    start   = 1'b1;
    tx_data = m;
    if (sload >= 0) begin
      chk("so_ready_load", so_ready, 1);
      so_start = 1'b1;
      so_data  = sload[7:0];
    end
    exp_rx.push_back(exp_m);
    if (exp_s >= 0) exp_si.push_back(exp_s);
    @(negedge clk);
    start    = 1'b0;
    so_start = 1'b0;
    n = 1;
    chk("tx_ready_busy", tx_ready, 0);
    while (!done && n < 20 * H) begin
      if (poke && n == 4 * H) begin
        start    = 1'b1;
        tx_data  = 8'h33;
        so_start = 1'b1;
        so_data  = 8'h00;
        chk("so_ready_busy", so_ready, 0);
      end else begin
        start    = 1'b0;
        so_start = 1'b0;
      end
      if (cs_at != 0 && n == cs_at) cs = 1'b1;
      @(negedge clk);
      n++;
    end
    start    = 1'b0;
    so_start = 1'b0;
    chk("done_seen", done, 1);
    if (timed) chk("done_latency", n, 16 * H + 1);
    chk("tx_ready_at_done", tx_ready, 0);
  endtask

  initial begin
    int nd, ns;
    tick(3);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_done", done, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_miso", miso, 0);
    chk("rst_si_data", si_data, 0);
    chk("rst_si_done", si_done, 0);
    chk("rst_so_ready", so_ready, 1);
    rst_n = 1'b1;
    tick(3);
    cs = 1'b0;
    tick(4);

    // Mode 0
    xfer(8'hF0, 8'hAA, 8'hF0, 8'hAA, 1'b1, 1'b0, 0);
    @(negedge clk);
    chk("tx_ready_after", tx_ready, 1);
    tick(8);
    chk("mosi_bits", mosi_cap, 8'hF0);
    chk("so_ready_after", so_ready, 1);
    chk("si_done_count0", n_si, 1);
    chk("done_count0", n_done, 1);

    // Modes 1..3
    for (int md = 1; md < 4; md++) begin
      cs   = 1'b1;
      cpol = md[1];
      cpha = md[0];
      tick(6);
      chk("sclk_idle_pre", sclk, cpol);
      cs = 1'b0;
      tick(4);
      xfer(8'h0F, 8'h55, 8'h0F, 8'h55, 1'b1, 1'b0, 0);
      tick(8);
      chk("sclk_idle_post", sclk, cpol);
    end
    chk("si_done_count1", n_si, 4);

    // Back-to-back, mode 0
    cs   = 1'b1;
    cpol = 1'b0;
    cpha = 1'b0;
    tick(6);
    cs = 1'b0;
    tick(4);
    nd = n_done;
    ns = n_si;
    xfer(8'hAA, 8'h3C, 8'hAA, 8'h3C, 1'b1, 1'b0, 0);
    @(negedge clk);
    xfer(8'h55, 8'hC3, 8'h55, 8'hC3, 1'b1, 1'b0, 0);
    tick(8);
    chk("b2b_done_count", n_done, nd + 2);
    chk("b2b_si_count", n_si, ns + 2);

    // start and so_start while busy are ignored
    xfer(8'h96, 8'h69, 8'h96, 8'h69, 1'b0, 1'b1, 0);
    tick(8);

    // cs raised mid-byte aborts the slave
    ns = n_si;
    xfer(8'h3C, -1, -1, 8'hAA, 1'b0, 1'b0, 8 * H + 2);
    tick(8);
    chk("abort_no_si_done", n_si, ns);
    chk("abort_so_ready", so_ready, 1);
    chk("abort_miso", miso, 0);
    cs = 1'b0;
    tick(4);
    xfer(8'hA5, 8'h5A, 8'hA5, 8'h5A, 1'b0, 1'b0, 0);
    tick(8);

    // Reset mid-transfer
    start    = 1'b1;
    tx_data  = 8'h77;
    so_start = 1'b1;
    so_data  = 8'h11;
    @(negedge clk);
    start    = 1'b0;
    so_start = 1'b0;
    tick(5 * H);
    nd = n_done;
    ns = n_si;
    rst_n = 1'b0;
    tick(1);
    chk("mid_rst_sclk", sclk, 0);
    chk("mid_rst_mosi", mosi, 0);
    chk("mid_rst_rx_data", rx_data, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_tx_ready", tx_ready, 1);
    chk("mid_rst_miso", miso, 0);
    chk("mid_rst_si_data", si_data, 0);
    chk("mid_rst_si_done", si_done, 0);
    chk("mid_rst_so_ready", so_ready, 1);
    tick(2);
    rst_n = 1'b1;
    tick(20 * H);
    chk("mid_rst_no_done", n_done, nd);
    chk("mid_rst_no_si_done", n_si, ns);
    xfer(8'hC3, 8'h3C, 8'hC3, 8'h3C, 1'b1, 1'b0, 0);
    tick(8);

    chk("rx_queue_empty", exp_rx.size(), 0);
    chk("si_queue_empty", exp_si.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_master_slave.md
# spi_master_slave

Loopback-capable SPI block: an SPI master (byte-wide, mode 0-3, MSB first) and an SPI slave sharing one system clock, wired via the four SPI pins. The master generates SCLK/MOSI from a start/tx_data handshake. The slave, selected by an externally driven chip select, shifts MOSI into a receive byte and MISO out of a loaded transmit byte. It sits between a host-side controller and the SPI pins; both halves are instantiated here so one bench exercises a full-duplex transfer.

## Interface
- SCLK_HALF, 50: SCLK half-period in clk cycles; legal range is 4 or more.
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- cpol  input  1  SCLK idle level; sampled by both halves when a transfer starts. Must stay stable while busy.
- cpha  input  1  0: sample on leading edge, shift on trailing edge. 1: shift on leading edge, sample on trailing edge.
- start  input  1  master start request; honoured only while tx_ready=1.
- tx_data  input  8  master byte to send; captured with start.
- rx_data  output  8  master byte received from MISO; updated with done.
- tx_ready  output  1  master idle and able to accept start.
- done  output  1  one-cycle pulse at end of a master byte.
- sclk  output  1  serial clock driven by the master.
- mosi  output  1  master data out.
- miso  output  1  slave data out; 0 when cs=1.
- cs  input  1  active-low slave select; driven externally, not by the master.
- si_data  output  8  slave byte received from MOSI.
- si_done  output  1  one-cycle pulse when si_data is updated.
- so_data  input  8  slave byte to send; captured with so_start.
- so_start  input  1  slave load request; honoured only while so_ready=1.
- so_ready  output  1  slave transmit register empty and accepting a load.

## Operation
- Master FSM has states IDLE, XFER and DONE.
  - In IDLE, tx_ready=1 and sclk follows cpol.
  - On start in IDLE: latch tx_data, cpol and cpha; mosi←tx_data[7]; go to XFER.
- Each of the 8 bits lasts 2·SCLK_HALF clk cycles, split into a first half and a second half.
  - cpha=0: first half sclk=cpol, second half sclk=~cpol. MISO is sampled at entry to the second half. MOSI advances to the next bit at the end of the second half.
  - cpha=1: first half sclk=~cpol, second half sclk=cpol. MOSI is updated at the start of the first half, except bit 7, which is already presented. MISO is sampled at entry to the second half.
- After bit 0, sclk returns to cpol and the FSM enters DONE for one cycle.
  - In DONE: done=1 and rx_data←received byte, MSB first.
  - The FSM then returns to IDLE.
- start while the master is busy is ignored.
- Slave synchronises sclk, mosi and cs with 2-FF synchronisers, then detects sclk edges.
  - While cs=1, edges are ignored and the bit counter is cleared.
  - The slave uses the same cpol/cpha as the master.
- Slave receive: it samples MOSI on the edge type the master samples MISO on, shifting MSB first. On the 8th sample it sets si_data←byte and pulses si_done for one cycle.
- Slave transmit:
  - so_start while so_ready=1 loads so_data, sets miso←so_data[7] and drops so_ready.
  - It shifts to the next bit on the edge type the master shifts MOSI on. For cpha=1, the first leading edge does not shift.
  - After 8 bits, so_ready returns to 1.
  - If nothing is loaded, the slave shifts out 0.
- cs rising mid-byte aborts the slave transfer:
  - the bit counter is cleared;
  - no si_done is produced;
  - any loaded tx byte is discarded and so_ready returns to 1.

## Timing
- Reset values:
  - sclk=0, mosi=0, rx_data=0, done=0, tx_ready=1;
  - miso=0, si_data=0, si_done=0, so_ready=1;
  - all counters and shift registers are 0 and the FSM is in IDLE.
- Reset mid-transfer aborts immediately with no done and no si_done.
- With start sampled at cycle 0:
  - done is high at cycle 16·SCLK_HALF+1;
  - tx_ready is low from cycle 1 through the done cycle, and high on the following cycle.
- Slave edge-detection latency is 3 clk cycles after the sclk pin edge. SCLK_HALF≥4 guarantees miso settles before the master samples.
- si_done occurs 3 cycles after the 8th sampling edge at the pin.
- Back-to-back bytes: start may be asserted in the first cycle tx_ready is high again.

## Test plan
- Mode 0: cs=0, so_start with so_data=0xAA, start with tx_data=0xF0. MOSI carries 1111_0000. rx_data=0xAA at done, 16·SCLK_HALF+1 cycles after start. si_data=0xF0 with a single si_done. so_ready=1 afterwards.
- Modes 1, 2 and 3 with master 0x0F and slave 0x55: rx_data=0x55 and si_data=0x0F. sclk idles at cpol before and after.
- Back-to-back bytes 0xAA then 0x55 with cs held low: two done pulses, two si_done pulses, and correct data for each byte.
- start pulsed while busy: ignored, and the in-flight byte completes unchanged. so_start while so_ready=0: ignored.
- cs raised after 4 sclk periods: no si_done and so_ready=1. The next byte under cs=0 is received correctly from bit 7.
- reset=0 mid-transfer: all outputs take their reset values, tx_ready=1, and a subsequent mode-0 byte transfers correctly.
